// File: rtl/processor_8085_multi.sv
// Multi-cycle 8085-style core: FETCH/DECODE/EXECUTE sequencer with internal
// program memory and register file, run/stall control and a HALT state.
module processor_8085_multi #(
  parameter int DW     = 8,
  parameter int NREG   = 7,
  parameter int RAW    = 3,
  parameter int PAW    = 5,
  parameter int PDEPTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  output logic [DW-1:0] ACC,
  output logic          cy,
  output logic          z,
  output logic [PAW-1:0] pc,
  output logic          halted,
  output logic          instr_done
);

  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, HALT} state_t;

  localparam logic [3:0] OP_NOP = 4'h0, OP_MOVAR = 4'h1, OP_MOVRA = 4'h2, OP_MVI = 4'h3,
                         OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SUB = 4'h6, OP_ANA = 4'h7,
                         OP_ORA = 4'h8, OP_XRA = 4'h9, OP_INR = 4'hA, OP_DCR = 4'hB,
                         OP_JMP = 4'hC, OP_JZ = 4'hD, OP_JC = 4'hE, OP_HLT = 4'hF;

  logic [DW+3:0] pmem [0:PDEPTH-1];
  logic [DW-1:0] regfile_8085 [0:NREG-1];

  state_t         state, state_next;
  logic [DW+3:0]  ir, fetch_word;
  logic [DW-1:0]  opr, operand;
  logic [3:0]     op;
  logic [DW-1:0]  imm;
  logic [RAW-1:0] ridx;
  logic [PAW-1:0] target;
  logic           ridx_ok;

  logic [DW-1:0]  acc_next;
  logic           cy_next, z_next, reg_we;
  logic [PAW-1:0] pc_next;
  logic [DW:0]    sum;

  assign op      = ir[DW+3:DW];
  assign imm     = ir[DW-1:0];
  assign ridx    = imm[RAW-1:0];
  assign target  = imm[PAW-1:0];
  assign ridx_ok = int'(ridx) < NREG;

  // Addresses beyond the populated memory fetch as NOP
  always_comb begin
    fetch_word = '0;
    if (int'(pc) < PDEPTH) fetch_word = pmem[pc];
  end

  always_comb begin
    operand = '0;
    if (ridx_ok) operand = regfile_8085[ridx];
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:   state_next = DECODE;
      DECODE:  state_next = EXECUTE;
      EXECUTE: state_next = (op == OP_HLT) ? HALT : FETCH;
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  // Flags consumed here are the registered values from before this EXECUTE
  always_comb begin
    acc_next = ACC;
    cy_next  = cy;
    z_next   = z;
    pc_next  = pc;
    reg_we   = 1'b0;
    sum      = '0;
    case (op)
      OP_NOP:   ;
      OP_MOVAR: acc_next = opr;
      OP_MOVRA: reg_we = ridx_ok;
      OP_MVI:   acc_next = imm;
      OP_ADD: begin
        sum = {1'b0, ACC} + {1'b0, opr};
        {cy_next, acc_next} = sum;
        z_next = (sum[DW-1:0] == '0);
      end
      OP_ADC: begin
        sum = {1'b0, ACC} + {1'b0, opr} + {{DW{1'b0}}, cy};
        {cy_next, acc_next} = sum;
        z_next = (sum[DW-1:0] == '0);
      end
      OP_SUB: begin
        sum = {1'b0, ACC} - {1'b0, opr};
        {cy_next, acc_next} = sum;
        z_next = (sum[DW-1:0] == '0);
      end
      OP_ANA: begin
        acc_next = ACC & opr;
        cy_next  = 1'b0;
        z_next   = ((ACC & opr) == '0);
      end
      OP_ORA: begin
        acc_next = ACC | opr;
        cy_next  = 1'b0;
        z_next   = ((ACC | opr) == '0);
      end
      OP_XRA: begin
        acc_next = ACC ^ opr;
        cy_next  = 1'b0;
        z_next   = ((ACC ^ opr) == '0);
      end
      OP_INR: begin
        acc_next = ACC + DW'(1);
        z_next   = (acc_next == '0);
      end
      OP_DCR: begin
        acc_next = ACC - DW'(1);
        z_next   = (acc_next == '0);
      end
      OP_JMP:   pc_next = target;
      OP_JZ:    if (z)  pc_next = target;
      OP_JC:    if (cy) pc_next = target;
      OP_HLT:   ;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= '0;
      ACC        <= '0;
      cy         <= 1'b0;
      z          <= 1'b0;
      halted     <= 1'b0;
      instr_done <= 1'b0;
      ir         <= '0;
      opr        <= '0;
    end else begin
      instr_done <= 1'b0;
      if (run) begin
        state <= state_next;
        case (state)
          FETCH: begin
            ir <= fetch_word;
            pc <= pc + PAW'(1);
          end
          DECODE: opr <= operand;
          EXECUTE: begin
            ACC        <= acc_next;
            cy         <= cy_next;
            z          <= z_next;
            pc         <= pc_next;
            instr_done <= 1'b1;
            if (op == OP_HLT) halted <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Register file is deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (rst_n && run && state == EXECUTE && reg_we)
      regfile_8085[ridx] <= ACC;
  end

endmodule
